// File: rtl/irq_onehot_arbiter.sv
// irq_onehot_arbiter
// Collects request events into a pending vector and hands them out one at a
// time as a strictly one-hot word over a valid/ready handshake. Grants rotate
// round-robin starting just after the most recently granted line. The one-hot
// word feeds the 8-to-3 encoder directly, so it is forced to zero whenever no
// grant is on offer.

module irq_onehot_arbiter #(
   parameter int N           = 8,
   parameter bit EDGE_DETECT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] data,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pending,
   output logic         overflow
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_stateNext;

   logic [N-1:0]   r_reqQ;
   logic [N-1:0]   r_pending;
   logic [N-1:0]   r_data;
   logic           r_valid;
   logic           r_overflow;
   logic [PW-1:0]  r_ptr;
   logic [PW-1:0]  r_grantIdx;

   logic [N-1:0]   w_rise;
   logic           w_acc;
   logic [N-1:0]   w_clr;
   logic           w_found;
   logic [PW-1:0]  w_pickIdx;
   logic [PW:0]    w_scan;
   logic [N-1:0]   w_grantOneHot;
   logic [PW-1:0]  w_ptrInc;

   logic [N-1:0]   w_dataNext;
   logic           w_validNext;
   logic [PW-1:0]  w_ptrNext;
   logic [PW-1:0]  w_grantIdxNext;

   // In edge mode only a 0->1 transition creates an event; in level mode a
   // high line re-raises its event every cycle.
   assign w_rise = EDGE_DETECT ? (req & ~r_reqQ) : req;

   // A grant leaves pending only on the edge the consumer takes it.
   assign w_acc = r_valid & ready;
   assign w_clr = w_acc ? r_data : '0;

   // Pointer moves to the line after the one just granted, wrapping at N.
   assign w_ptrInc = (r_grantIdx == PW'(N - 1)) ? '0 : (r_grantIdx + 1'b1);

   // Round-robin pick: scan ptr, ptr+1, ... wrapping, and keep the first hit.
   always_comb begin
      w_found   = 1'b0;
      w_pickIdx = '0;
      w_scan    = '0;
      for (int i = 0; i < N; i++) begin
         w_scan = {1'b0, r_ptr} + (PW + 1)'(i);
         if (w_scan >= (PW + 1)'(N)) begin
            w_scan = w_scan - (PW + 1)'(N);
         end
         if (!w_found && r_pending[w_scan[PW-1:0]]) begin
            w_found   = 1'b1;
            w_pickIdx = w_scan[PW-1:0];
         end
      end
   end

   assign w_grantOneHot = {{(N-1){1'b0}}, 1'b1} << w_pickIdx;

   // State register together with the registered handshake outputs and pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_ptr      <= '0;
         r_grantIdx <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_data     <= w_dataNext;
         r_valid    <= w_validNext;
         r_ptr      <= w_ptrNext;
         r_grantIdx <= w_grantIdxNext;
      end
   end

   // Next state: leave IDLE once anything is pending, leave OFFER on ready.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_found) w_stateNext = OFFER;
         OFFER:   if (ready)   w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Next outputs: load a grant from IDLE, hold it untouched through OFFER
   // until taken, then drop to zero and advance the pointer.
   always_comb begin
      w_dataNext     = r_data;
      w_validNext    = r_valid;
      w_ptrNext      = r_ptr;
      w_grantIdxNext = r_grantIdx;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_dataNext     = w_grantOneHot;
               w_validNext    = 1'b1;
               w_grantIdxNext = w_pickIdx;
            end else begin
               w_dataNext  = '0;
               w_validNext = 1'b0;
            end
         end
         OFFER: begin
            if (ready) begin
               w_dataNext  = '0;
               w_validNext = 1'b0;
               w_ptrNext   = w_ptrInc;
            end
         end
         default: begin
            w_dataNext  = '0;
            w_validNext = 1'b0;
         end
      endcase
   end

   // Event capture: new events win over a same-cycle clear, and an event
   // landing on a bit that stays pending raises a one-cycle overflow pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reqQ     <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_reqQ     <= req;
         r_pending  <= (r_pending & ~w_clr) | w_rise;
         r_overflow <= |(w_rise & r_pending & ~w_clr);
      end
   end

   assign data     = r_data;
   assign valid    = r_valid;
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// Bench for irq_onehot_arbiter: one edge-mode instance and one level-mode
// instance share a clock. Grants expected by the stimulus are queued and a
// monitor pops them whenever a handshake completes.

module tb_irq_onehot_arbiter;

   logic       clk = 1'b0;

   logic       rstA = 1'b1;
   logic [7:0] reqA = 8'h00;
   logic       readyA = 1'b0;
   logic [7:0] dataA;
   logic       validA;
   logic [7:0] pendingA;
   logic       overflowA;

   logic       rstL = 1'b1;
   logic [7:0] reqL = 8'h00;
   logic       readyL = 1'b0;
   logic [7:0] dataL;
   logic       validL;
   logic [7:0] pendingL;
   logic       overflowL;

   int checks = 0;
   int failures = 0;
   int overflowCountA = 0;
   logic [7:0] expQA[$];
   logic [7:0] expQL[$];

   irq_onehot_arbiter #(.N(8), .EDGE_DETECT(1'b1)) dutA (
      .clk(clk), .rst(rstA), .req(reqA), .data(dataA), .valid(validA),
      .ready(readyA), .pending(pendingA), .overflow(overflowA)
   );

   irq_onehot_arbiter #(.N(8), .EDGE_DETECT(1'b0)) dutL (
      .clk(clk), .rst(rstL), .req(reqL), .data(dataL), .valid(validL),
      .ready(readyL), .pending(pendingL), .overflow(overflowL)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Monitor: on the falling edge, a valid&ready pair means the next rising
   // edge completes a handshake, so the presented word is compared now.
   always @(negedge clk) begin
      if (validA && readyA) begin
         if (expQA.size() == 0) begin
            checkOutput("unexpected_grant_A", {24'h0, dataA}, 32'h0);
            if (dataA == 8'h00) begin
               failures++;
               $display("[TB] FAIL unexpected_grant_A actual=valid required=none");
            end
         end else begin
            checkOutput("grant_A", {24'h0, dataA}, {24'h0, expQA.pop_front()});
         end
      end
      if (validL && readyL) begin
         if (expQL.size() == 0) begin
            failures++;
            checks++;
            $display("[TB] FAIL unexpected_grant_L actual=%0h required=none", dataL);
         end else begin
            checkOutput("grant_L", {24'h0, dataL}, {24'h0, expQL.pop_front()});
         end
      end
      if (overflowA) overflowCountA++;
      // Structural invariants on every cycle.
      checkOutput("inv_shape_A", {31'h0, validA ? $onehot(dataA) : (dataA == 8'h00)}, 32'h1);
      checkOutput("inv_subset_A", {31'h0, !validA || ((dataA & ~pendingA) == 8'h00)}, 32'h1);
      checkOutput("inv_ptr_A", {31'h0, int'(dutA.r_ptr) < 8}, 32'h1);
      checkOutput("inv_shape_L", {31'h0, validL ? $onehot(dataL) : (dataL == 8'h00)}, 32'h1);
      checkOutput("inv_subset_L", {31'h0, !validL || ((dataL & ~pendingL) == 8'h00)}, 32'h1);
   end

   initial begin
      int ovStart;

      // ---------------- reset with all requests held high ----------------
      reqA = 8'hFF;
      applyStimulus(3);
      checkOutput("reset_valid", {31'h0, validA}, 32'h0);
      checkOutput("reset_data", {24'h0, dataA}, 32'h0);
      checkOutput("reset_pending", {24'h0, pendingA}, 32'h0);
      rstA = 1'b0;
      applyStimulus(1);
      checkOutput("rel_pending", {24'h0, pendingA}, 32'hFF);
      checkOutput("rel_valid", {31'h0, validA}, 32'h0);
      applyStimulus(1);
      checkOutput("first_valid", {31'h0, validA}, 32'h1);
      checkOutput("first_data", {24'h0, dataA}, 32'h01);
      expQA.push_back(8'h01);
      for (int b = 1; b < 8; b++) expQA.push_back(8'h01 << b);
      readyA = 1'b1;
      reqA = 8'h00;
      applyStimulus(18);
      checkOutput("drain_pending", {24'h0, pendingA}, 32'h0);
      checkOutput("drain_ptr", {29'h0, dutA.r_ptr}, 32'h0);
      checkOutput("drain_queue", expQA.size(), 32'h0);

      // ---------------- single walk, one request every 5 cycles ----------
      for (int i = 0; i < 8; i++) begin
         reqA = 8'h01 << i;
         expQA.push_back(8'h01 << i);
         applyStimulus(1);
         checkOutput("walk_pre_valid", {31'h0, validA}, 32'h0);
         reqA = 8'h00;
         applyStimulus(1);
         checkOutput("walk_valid", {31'h0, validA}, 32'h1);
         checkOutput("walk_data", {24'h0, dataA}, {24'h0, 8'h01 << i});
         applyStimulus(1);
         checkOutput("walk_post_valid", {31'h0, validA}, 32'h0);
         checkOutput("walk_ptr", {29'h0, dutA.r_ptr}, (i == 7) ? 32'h0 : i + 1);
         applyStimulus(2);
      end

      // ---------------- round-robin from a single edge --------------------
      reqA = 8'b1000_0101;
      expQA.push_back(8'h01);
      expQA.push_back(8'h04);
      expQA.push_back(8'h80);
      applyStimulus(1);
      checkOutput("rr_pending", {24'h0, pendingA}, 32'h85);
      reqA = 8'h00;
      applyStimulus(7);
      checkOutput("rr_ptr_wrap", {29'h0, dutA.r_ptr}, 32'h0);
      checkOutput("rr_pending_end", {24'h0, pendingA}, 32'h0);

      // ---------------- back-pressure ------------------------------------
      reqA = 8'h02;
      expQA.push_back(8'h02);
      applyStimulus(1);
      reqA = 8'h00;
      applyStimulus(3);
      checkOutput("bp_ptr_setup", {29'h0, dutA.r_ptr}, 32'h2);
      readyA = 1'b0;
      reqA = 8'h04;
      expQA.push_back(8'h04);
      expQA.push_back(8'h01);
      applyStimulus(1);
      reqA = 8'h00;
      applyStimulus(1);
      checkOutput("bp_offer", {24'h0, dataA}, 32'h04);
      reqA = 8'h01;
      applyStimulus(1);
      reqA = 8'h00;
      checkOutput("bp_pending", {24'h0, pendingA}, 32'h05);
      for (int c = 0; c < 6; c++) begin
         checkOutput("bp_hold_data", {24'h0, dataA}, 32'h04);
         checkOutput("bp_hold_valid", {31'h0, validA}, 32'h1);
         applyStimulus(1);
      end
      readyA = 1'b1;
      applyStimulus(1);
      checkOutput("bp_ptr_after", {29'h0, dutA.r_ptr}, 32'h3);
      applyStimulus(1);
      checkOutput("bp_next_grant", {24'h0, dataA}, 32'h01);
      applyStimulus(2);
      checkOutput("bp_ptr_end", {29'h0, dutA.r_ptr}, 32'h1);

      // ---------------- set wins / overflow -------------------------------
      ovStart = overflowCountA;
      reqA = 8'h04;
      expQA.push_back(8'h04);
      expQA.push_back(8'h04);
      applyStimulus(1);
      reqA = 8'h00;
      applyStimulus(1);
      checkOutput("sw_offer", {24'h0, dataA}, 32'h04);
      reqA = 8'h04;
      applyStimulus(1);
      reqA = 8'h00;
      readyA = 1'b0;
      checkOutput("sw_still_pending", {24'h0, pendingA}, 32'h04);
      checkOutput("sw_no_overflow", {31'h0, overflowA}, 32'h0);
      applyStimulus(1);
      checkOutput("sw_regrant", {24'h0, dataA}, 32'h04);
      reqA = 8'h04;
      applyStimulus(1);
      reqA = 8'h00;
      checkOutput("sw_overflow", {31'h0, overflowA}, 32'h1);
      applyStimulus(1);
      checkOutput("sw_overflow_pulse", {31'h0, overflowA}, 32'h0);
      readyA = 1'b1;
      applyStimulus(3);
      checkOutput("sw_overflow_count", overflowCountA - ovStart, 32'h1);
      checkOutput("sw_pending_end", {24'h0, pendingA}, 32'h0);

      // ---------------- reset during OFFER --------------------------------
      readyA = 1'b0;
      reqA = 8'h01;
      applyStimulus(1);
      reqA = 8'h00;
      applyStimulus(1);
      checkOutput("mid_offer_valid", {31'h0, validA}, 32'h1);
      rstA = 1'b1;
      #1;
      checkOutput("mid_rst_valid", {31'h0, validA}, 32'h0);
      checkOutput("mid_rst_data", {24'h0, dataA}, 32'h0);
      checkOutput("mid_rst_pending", {24'h0, pendingA}, 32'h0);
      applyStimulus(1);
      rstA = 1'b0;
      applyStimulus(2);
      checkOutput("mid_rst_idle", {31'h0, validA}, 32'h0);
      checkOutput("mid_rst_ptr", {29'h0, dutA.r_ptr}, 32'h0);

      // ---------------- level mode ----------------------------------------
      reqL = 8'h02;
      readyL = 1'b1;
      for (int g = 0; g < 5; g++) expQL.push_back(8'h02);
      rstL = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1);
         checkOutput("lvl_valid", {31'h0, validL}, (k >= 2 && k % 2 == 0) ? 32'h1 : 32'h0);
         checkOutput("lvl_overflow", {31'h0, overflowL}, (k >= 2 && k % 2 == 0) ? 32'h1 : 32'h0);
      end
      reqL = 8'h00;
      applyStimulus(1);
      checkOutput("lvl_end_valid", {31'h0, validL}, 32'h0);
      checkOutput("lvl_end_pending", {24'h0, pendingL}, 32'h0);
      applyStimulus(2);

      checkOutput("queue_A_empty", expQA.size(), 32'h0);
      checkOutput("queue_L_empty", expQL.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_onehot_arbiter.md
Name: irq_onehot_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures up to 8 asynchronous-to-protocol request lines into a pending register.
- Picks one pending request per grant using round-robin, and presents it as a strictly one-hot 8-bit word with a valid/ready handshake.
- The `data` output connects directly to the encoder's data input. The encoder's code output is only meaningful while `valid` is high.

Parameters:
- N, 8, number of request lines and width of the one-hot output. Only 8 is supported at integration, but the RTL must be generic for N ≥ 2.
- EDGE_DETECT, 1, selects how a pending bit is set:
  - 1: a rising edge of `req[i]` sets pending bit i.
  - 0: a high level of `req[i]` sets pending bit i every cycle.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request lines, synchronous to `clk`.
- data  output  N  registered one-hot grant word to the encoder; all zeros when `valid` = 0.
- valid  output  1  registered; `data` holds a grant.
- ready  input  1  consumer accepts `data` on a rising edge where `valid` & `ready` = 1.
- pending  output  N  registered pending-request vector.
- overflow  output  1  registered one-cycle pulse: a new event hit a bit that was already pending.

Behaviour:
- Reset (async, `rst` = 1): the following are all 0: `req_q`, `pending`, `data`, `valid`, `overflow`, round-robin pointer `ptr`, and state. State = IDLE.
- After reset release, `req_q` = 0. A `req` bit held high through reset therefore counts as a rising edge on the first clock edge.
- Event vector:
  - `rise` = `req` & ~`req_q` when EDGE_DETECT = 1.
  - `rise` = `req` when EDGE_DETECT = 0.
  - `req_q` <= `req` every clock.
- Accept: `acc` = `valid` & `ready`. `clr` = `data` when `acc` = 1, else 0.
- Pending update: `pending` <= (`pending` & ~`clr`) | `rise`.
  - Set wins: if bit i is cleared and risen in the same cycle, it stays pending as a new event.
- Overflow: `overflow` <= |(`rise` & `pending` & ~`clr`). This is a pulse, not sticky.
  - In level mode, a held `req` pulses `overflow` every cycle the bit is still pending. This is accepted behaviour.
- State machine:
  - IDLE:
    - If `pending` != 0, select index k = first set bit scanning `ptr`, `ptr`+1, … N-1, 0, …, `ptr`-1.
    - Load `data` <= one-hot(k), `valid` <= 1, go to OFFER.
    - Only the registered `pending` is used; same-cycle `rise` is not seen.
    - Otherwise stay in IDLE with `data` = 0.
  - OFFER:
    - While `ready` = 0, hold `data` and `valid` stable. No re-arbitration, even if higher-priority bits arrive.
    - On `ready` = 1: clear the granted pending bit, `ptr` <= (k+1) mod N, `valid` <= 0, `data` <= 0, go to IDLE.
- Latency and throughput:
  - Edge-mode `req` rise sampled at edge t sets `pending` at t; `valid` rises at t+1.
  - Maximum throughput is one grant per 2 cycles (mandatory bubble in IDLE).
- Invariants (assert in bench):
  - `data` is one-hot when `valid` = 1 and zero when `valid` = 0.
  - `data` is a subset of `pending` while `valid` = 1.
  - `ptr` is always < N.
- Wrap-around: `ptr` = N-1 after granting index N-2; granting N-1 sets `ptr` to 0.
- Reset mid-OFFER: `valid` and `data` drop asynchronously. The grant is lost and no `pending` bit is retained.
- `ready` high while `valid` = 0: ignored.

Test Plan:
- Reset: `rst` = 1 with `req` = 8'hFF, then release. Required: `valid` = 0, `data` = 0 during reset; `pending` = 8'hFF one edge after release; `valid` = 1, `data` = 8'b0000_0001 on the next edge.
- Single walk: edge mode, `ready` tied 1, pulse `req` = 8'b0000_0001, shifted left one bit every 5 cycles. Required: each `data` equals the request bit, valid for exactly 1 cycle, 2 edges after the rise; the encoder code downstream steps 0..7.
- Round-robin: `pending` = 8'b1000_0101 from a single edge, `ready` = 1. Required grant order 8'h01, 8'h04, 8'h80, with `ptr` ending at 0 after wrap.
- Back-pressure: `ready` = 0 for 6 cycles while `data` = 8'h04 and `req` bit 0 rises. Required: `data` stable at 8'h04, no re-arbitration; after `ready` = 1, the next grant is 8'h01 (wrap from `ptr` = 3).
- Set-wins/overflow: re-pulse `req[2]` in the accept cycle of grant 8'h04, then pulse again while pending. Required: bit 2 stays pending and is granted again; `overflow` pulses exactly once, on the second pulse.
- Level mode (EDGE_DETECT = 0): `req` = 8'h02 held, `ready` = 1. Required: 8'h02 granted every 2 cycles; `overflow` asserted on each non-accept cycle.
